// File: rtl/univ_shift_pkg.sv
// Shared types for the universal shift register.
//   mode_e   - 3-bit operation select driven on univ_shift_reg.mode
//   is_shift - true for the modes that move bits and advance the frame counter
package univ_shift_pkg;

    typedef enum logic [2:0] {
        ModeHold  = 3'b000,
        ModeShl   = 3'b001,
        ModeShr   = 3'b010,
        ModeRol   = 3'b011,
        ModeRor   = 3'b100,
        ModeLoad  = 3'b101,
        ModeClear = 3'b110,
        ModeAsr   = 3'b111
    } mode_e;

    function automatic logic is_shift(input mode_e m);
        return m inside {ModeShl, ModeShr, ModeRol, ModeRor, ModeAsr};
    endfunction

endpackage

// File: rtl/shift_count.sv
// Saturating frame counter with a completion pulse.
// Ports:
//   clk        - rising-edge clock
//   rst        - synchronous active-high reset
//   en         - cycle enable; when low the count holds and the pulse drops
//   inc        - advance the count by one (saturates at MAX)
//   clr        - restart the count at zero; wins over inc
//   cnt        - current count, 0..MAX
//   done_pulse - one-cycle pulse after the edge on which cnt reaches MAX
module shift_count #(
    parameter int unsigned MAX = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       inc,
    input  logic                       clr,
    output logic [$clog2(MAX+1)-1:0]   cnt,
    output logic                       done_pulse
);

    localparam int unsigned CW = $clog2(MAX + 1);

    logic [CW-1:0] cnt_q;
    logic          done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else if (en) begin
            if (clr) begin
                cnt_q  <= '0;
                done_q <= 1'b0;
            end else if (inc && (cnt_q != CW'(MAX))) begin
                cnt_q  <= cnt_q + CW'(1);
                // Pulse only on the step into MAX; saturated shifts stay quiet.
                done_q <= (cnt_q == CW'(MAX - 1));
            end else begin
                done_q <= 1'b0;
            end
        end else begin
            done_q <= 1'b0;
        end
    end

    assign cnt        = cnt_q;
    assign done_pulse = done_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit shift register: hold, shift left/right, rotate,
// arithmetic shift right, parallel load and clear, plus a frame bit-counter.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   en                - cycle enable; when low all state holds
//   mode              - operation select (mode_e)
//   sin_r / sin_l     - serial in at bit 0 (SHL) / bit WIDTH-1 (SHR)
//   pdata             - parallel load data
//   q                 - register contents
//   sout_msb/sout_lsb - q[WIDTH-1] / q[0] straight from the register
//   cnt               - shifts since last LOAD/CLEAR/reset, saturating at WIDTH
//   frame_done        - one-cycle pulse after cnt reaches WIDTH
//   parity            - registered ^q (only with UNIV_SHIFT_PARITY_EN defined)
module univ_shift_reg
    import univ_shift_pkg::*;
#(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  mode_e                        mode,
    input  logic                         sin_r,
    input  logic                         sin_l,
    input  logic [WIDTH-1:0]             pdata,
    output logic [WIDTH-1:0]             q,
    output logic                         sout_msb,
    output logic                         sout_lsb,
    output logic [$clog2(WIDTH+1)-1:0]   cnt,
`ifdef UNIV_SHIFT_PARITY_EN
    output logic                         frame_done,
    output logic                         parity
`else
    output logic                         frame_done
`endif
);

    logic [WIDTH-1:0] q_d, q_q;

    always_comb begin
        q_d = q_q;
        unique case (mode)
            ModeHold:  q_d = q_q;
            ModeShl:   q_d = {q_q[WIDTH-2:0], sin_r};
            ModeShr:   q_d = {sin_l, q_q[WIDTH-1:1]};
            ModeRol:   q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            ModeRor:   q_d = {q_q[0], q_q[WIDTH-1:1]};
            ModeLoad:  q_d = pdata;
            ModeClear: q_d = '0;
            ModeAsr:   q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
            default:   q_d = q_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= RST_VAL;
        end else if (en) begin
            q_q <= q_d;
        end
    end

`ifdef UNIV_SHIFT_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q <= ^RST_VAL;
        end else if (en) begin
            parity_q <= ^q_d;
        end
    end

    assign parity = parity_q;
`endif

    shift_count #(
        .MAX(WIDTH)
    ) u_shift_count (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .inc       (is_shift(mode)),
        .clr       ((mode == ModeLoad) || (mode == ModeClear)),
        .cnt       (cnt),
        .done_pulse(frame_done)
    );

    assign q        = q_q;
    assign sout_msb = q_q[WIDTH-1];
    assign sout_lsb = q_q[0];

endmodule
